vehicle_sensor_conditioner: RTL and testbench
=============================================

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: the number of consecutive synchronized-high cycles that confirm an arrival.
REQ-002 SHALL have parameter HOLD_CYCLES, default 6: the number of consecutive synchronized-low cycles that confirm a departure.
REQ-003 SHALL have parameter CNT_W, default 8: the width of the vehicle counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port loop_raw, input, 1 bit: the raw inductive-loop detector, asynchronous to clk and may glitch.
REQ-007 SHALL have port svc_ack, input, 1 bit: the service acknowledge, driven by the traffic light controller's EW_Green.
REQ-008 SHALL have port sensor, output, 1 bit: the latched service request, driving the traffic light controller's sensor input.
REQ-009 SHALL have port vehicle_present, output, 1 bit: the debounced vehicle-present level.
REQ-010 SHALL have port vehicle_count, output, CNT_W bits: the saturating count of confirmed arrivals.

Function
REQ-011 SHALL pass loop_raw through a 2-flop synchronizer; loop_s denotes the second flop's output.
REQ-012 SHALL implement a 4-state FSM with states IDLE, CONFIRM_ON, PRESENT and CONFIRM_OFF, plus a debounce counter deb_cnt sized for max(DEB_CYCLES, HOLD_CYCLES).
REQ-013 SHALL, in IDLE: if loop_s=1, go to CONFIRM_ON with deb_cnt=1; otherwise stay.
REQ-014 SHALL, in CONFIRM_ON: if loop_s=0, go to IDLE; else if deb_cnt==DEB_CYCLES-1, go to PRESENT; else increment deb_cnt.
REQ-015 SHALL, in PRESENT: if loop_s=0, go to CONFIRM_OFF with deb_cnt=1; otherwise stay.
REQ-016 SHALL, in CONFIRM_OFF: if loop_s=1, go to PRESENT (dropout forgiven, no new arrival); else if deb_cnt==HOLD_CYCLES-1, go to IDLE; else increment deb_cnt.
REQ-017 SHALL drive vehicle_present=1 exactly when the state is PRESENT or CONFIRM_OFF, decoded from registered state only.
REQ-018 SHALL define latency: with loop_raw stable high before edge N, vehicle_present rises after edge N+1+DEB_CYCLES; with loop_raw stable low before edge M, it falls after edge M+1+HOLD_CYCLES.
REQ-019 SHALL increment vehicle_count by 1 only on the CONFIRM_ON->PRESENT transition, saturating at 2^CNT_W-1 with no wrap.
REQ-020 SHALL set the sensor latch on the CONFIRM_ON->PRESENT transition.
REQ-021 SHALL clear the sensor latch on an edge where svc_ack=1 and the state is IDLE or CONFIRM_ON (vehicle departed).
REQ-022 SHALL give set priority over clear when both occur on the same edge, so sensor stays 1.
REQ-023 SHALL keep sensor at 1 while svc_ack=1 and vehicle_present=1, since the request is serviced only once the vehicle has left.
REQ-024 SHALL drive sensor from a flop with no combinational path from loop_raw or svc_ack.
REQ-025 SHALL treat DEB_CYCLES=1 or HOLD_CYCLES=1 as a single confirmation cycle; values of 0 are illegal and are flagged by a simulation assertion.

Reset
REQ-026 SHALL, while rst=0, immediately force: both synchronizer flops=0, state=IDLE, deb_cnt=0, sensor=0, vehicle_present=0, vehicle_count=0.
REQ-027 SHALL, on reset assertion mid-operation (any state), abandon the pending request and the partial debounce with no residual output.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit) and the default DEB_CYCLES, HOLD_CYCLES and CNT_W constants in the shared package traffic_pkg, which is also usable by traffic_light_controller.
REQ-030 SHALL implement the synchronizer as the sub-module sync_2ff (1-bit, clk, rst active-low async); all other logic is in one module.

Verification (DEB_CYCLES=4, HOLD_CYCLES=6)
REQ-031 SHALL cover reset: rst=0 for 2 cycles with loop_raw=1 -> sensor=0, vehicle_present=0, vehicle_count=0 throughout.
REQ-032 SHALL cover a clean vehicle: loop_raw=1 before edge 10 and held until before edge 30 -> vehicle_present and sensor rise after edge 15, vehicle_count=1, vehicle_present falls after edge 37.
REQ-033 SHALL cover a glitch: loop_raw=1 for 3 cycles then 0 -> no change on any output, vehicle_count=0.
REQ-034 SHALL cover a dropout: in PRESENT, loop_raw=0 for 3 cycles then 1 -> vehicle_present stays 1, vehicle_count unchanged.
REQ-035 SHALL cover the handshake: svc_ack=1 while vehicle_present=1 -> sensor stays 1; after the return to IDLE with svc_ack=1 -> sensor=0 on the next edge; a new arrival confirmed on the same edge as a clear -> sensor=1.
REQ-036 SHALL cover saturation: 300 clean vehicles -> vehicle_count=255 and holds; then rst=0 mid-CONFIRM_ON -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller family: vehicle
// detector FSM encoding and default timing/counter constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CONFIRM_ON  = 2'd1,
    PRESENT     = 2'd2,
    CONFIRM_OFF = 2'd3
  } veh_state_t;

  localparam int unsigned DEF_DEB_CYCLES  = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 6;
  localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Debounces an inductive-loop detector, counts confirmed arrivals and holds a
// service request for the light controller until the vehicle has left.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             svc_ack,
  output logic             sensor,
  output logic             vehicle_present,
  output logic [CNT_W-1:0] vehicle_count
);

  localparam int unsigned MAX_CYC   = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int unsigned DEB_W     = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] HOLD_LAST = DEB_W'(HOLD_CYCLES - 1);

  logic             loop_s;
  veh_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             arrive;
  logic             svc_clear;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (loop_raw),
    .q   (loop_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
    end
  end

  // '>=' rather than '==' so a window of one cycle confirms on the first check.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    arrive  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (loop_s) begin
          state_d = CONFIRM_ON;
          deb_d   = DEB_W'(1);
        end
      end
      CONFIRM_ON: begin
        if (!loop_s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q >= DEB_LAST) begin
          state_d = PRESENT;
          deb_d   = '0;
          arrive  = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESENT: begin
        if (!loop_s) begin
          state_d = CONFIRM_OFF;
          deb_d   = DEB_W'(1);
        end
      end
      CONFIRM_OFF: begin
        if (loop_s) begin
          state_d = PRESENT;
          deb_d   = '0;
        end else if (deb_q >= HOLD_LAST) begin
          state_d = IDLE;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end

  always_comb begin
    vehicle_present = (state_q == PRESENT) || (state_q == CONFIRM_OFF);
    svc_clear       = svc_ack && ((state_q == IDLE) || (state_q == CONFIRM_ON));
  end

  // A new arrival on the same edge as an acknowledge keeps the request alive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sensor        <= 1'b0;
      vehicle_count <= '0;
    end else begin
      if (arrive)
        sensor <= 1'b1;
      else if (svc_clear)
        sensor <= 1'b0;
      if (arrive && (vehicle_count != '1))
        vehicle_count <= vehicle_count + 1'b1;
    end
  end

  assert property (@(posedge clk) (DEB_CYCLES != 0) && (HOLD_CYCLES != 0))
    else $error("vehicle_sensor_conditioner: DEB_CYCLES and HOLD_CYCLES must be nonzero");

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Randomized and directed scoreboard bench for vehicle_sensor_conditioner.
module tb_vehicle_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 6;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          loop_raw;
  logic          svc_ack;
  logic          sensor;
  logic          vehicle_present;
  logic [CW-1:0] vehicle_count;

  vehicle_sensor_conditioner #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .loop_raw        (loop_raw),
    .svc_ack         (svc_ack),
    .sensor          (sensor),
    .vehicle_present (vehicle_present),
    .vehicle_count   (vehicle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vp;
    bit sn;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a vehicle is seen after DEB consecutive synchronized
  // highs and leaves after HOLD consecutive synchronized lows.
  bit m_present, m_sensor, h1, h2;
  int m_run, m_count;
  bit prev_r = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input bit a);
    bit s, arrive, pres_before;
    if (!r) begin
      m_present = 0; m_sensor = 0; m_run = 0; m_count = 0; h1 = 0; h2 = 0;
    end else begin
      s = h2;
      arrive = 0;
      pres_before = m_present;
      if (!m_present) begin
        if (s) begin
          m_run++;
          if (m_run >= DEB) begin m_present = 1; m_run = 0; arrive = 1; end
        end else m_run = 0;
      end else begin
        if (!s) begin
          m_run++;
          if (m_run >= HOLD) begin m_present = 0; m_run = 0; end
        end else m_run = 0;
      end
      if (arrive) begin
        m_sensor = 1;
        if (m_count < CMAX) m_count++;
      end else if (a && !pres_before) begin
        m_sensor = 0;
      end
      h2 = h1;
      h1 = l;
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit a);
    exp_t e;
    rst = r; loop_raw = l; svc_ack = a;
    model_edge(r, l, a);
    e.vp = m_present; e.sn = m_sensor; e.cnt = m_count;
    exp_q.push_back(e);
    if (!r && prev_r) begin
      #1;
      chk("async_rst_present", int'(vehicle_present), 0);
      chk("async_rst_sensor",  int'(sensor), 0);
      chk("async_rst_count",   int'(vehicle_count), 0);
    end
    prev_r = r;
    @(negedge clk);
  endtask

  task automatic run(input bit r, input bit l, input bit a, input int n);
    for (int i = 0; i < n; i++) drive(r, l, a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty got=0 want=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("vehicle_present", int'(vehicle_present), int'(e.vp));
        chk("sensor",          int'(sensor),          int'(e.sn));
        chk("vehicle_count",   int'(vehicle_count),   e.cnt);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    // reset held with the loop occupied
    run(0, 1, 0, 2);
    run(1, 0, 0, 3);
    // clean vehicle
    run(1, 1, 0, 20);
    run(1, 0, 0, 12);
    // glitch shorter than the confirmation window
    run(1, 1, 0, 3);
    run(1, 0, 0, 10);
    // dropout while present, acknowledge while present then after departure
    run(1, 1, 0, 10);
    run(1, 0, 0, 3);
    run(1, 1, 1, 6);
    run(1, 0, 1, 12);
    run(1, 0, 0, 2);
    // arrival confirmed on the same edge as an acknowledge
    run(1, 1, 0, 8);
    run(1, 0, 0, 10);
    run(1, 1, 0, 5);
    run(1, 1, 1, 1);
    run(1, 1, 0, 5);
    run(1, 0, 0, 10);
    // random loop activity and acknowledges
    for (int seg = 0; seg < 80; seg++) begin
      bit l;
      int len;
      l   = bit'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      for (int k = 0; k < len; k++) drive(1, l, ($urandom_range(0, 9) < 3));
    end
    // saturation
    run(1, 0, 0, 8);
    for (int v = 0; v < 300; v++) begin
      run(1, 1, 0, 5);
      run(1, 0, 0, 7);
    end
    run(1, 0, 0, 4);
    // reset while confirming an arrival
    run(1, 1, 0, 3);
    run(0, 1, 0, 3);
    run(1, 0, 0, 5);
    run(1, 1, 0, 8);
    run(1, 0, 0, 8);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
